// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control slice: MDU sequencer states and the
// default stall-counter width.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide hold sequencer; present only when HAZARD_MDU_EN is defined,
// otherwise the hold output is tied low and the inputs are ignored.
module mdu_seq
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mdu_startE,
    input  logic mdu_ready,
    input  logic excM,
    output logic mdu_hold
);

`ifdef HAZARD_MDU_EN
    mdu_state_t state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE deliberately ignores mdu_startE: the finished instruction is
    // still in E during its release cycle and must not restart.
    always_comb begin
        state_next = state;
        mdu_hold   = 1'b0;
        case (state)
            IDLE: begin
                if (mdu_startE && !excM) begin
                    state_next = BUSY;
                    mdu_hold   = 1'b1;
                end
            end
            BUSY: begin
                mdu_hold = 1'b1;
                if (excM) begin
                    state_next = IDLE;
                end else if (mdu_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
`else
    logic unused_mdu;
    assign unused_mdu = clk ^ rst_n ^ mdu_startE ^ mdu_ready ^ excM;
    assign mdu_hold   = 1'b0;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a saturating stall counter.
// The MDU hold sequence is built only when HAZARD_MDU_EN is defined.
`ifndef REG_SIZE
`define REG_SIZE 4:0
`endif

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [`REG_SIZE] rsD,
    input  logic [`REG_SIZE] rtD,
    input  logic [`REG_SIZE] rtE,
    input  logic [`REG_SIZE] writeRegAddrE,
    input  logic [`REG_SIZE] writeRegAddrM,
    input  logic             Regfile_weE,
    input  logic             memToRegE,
    input  logic             memToRegM,
    input  logic             branchD,
    input  logic             jrD,
    input  logic             pcSrcD,
    input  logic             excM,
    input  logic             mdu_startE,
    input  logic             mdu_ready,
    input  logic             cnt_clr,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic lwstall;
    logic brstall;
    logic mdu_hold;

    mdu_seq u_mdu_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdu_startE (mdu_startE),
        .mdu_ready  (mdu_ready),
        .excM       (excM),
        .mdu_hold   (mdu_hold)
    );

    assign lwstall = memToRegE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

    assign brstall = (branchD || jrD) &&
                     ((Regfile_weE && (writeRegAddrE != '0) &&
                       ((writeRegAddrE == rsD) || (writeRegAddrE == rtD))) ||
                      (memToRegM && (writeRegAddrM != '0) &&
                       ((writeRegAddrM == rsD) || (writeRegAddrM == rtD))));

    // Reset gates every control low combinationally, ahead of the priority chain.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (!rst_n) begin
            flushD = 1'b0;
        end else if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mdu_hold) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstall || brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else begin
            flushD = pcSrcD;
        end
    end

    assign mdu_busy = rst_n && mdu_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stallF && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed
// by random stimulus, compared against a behavioural model of the hazard rules.
`ifndef REG_SIZE
`define REG_SIZE 4:0
`endif

module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW      = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic             clk;
    logic             rst_n;
    logic [`REG_SIZE] rsD, rtD, rtE, writeRegAddrE, writeRegAddrM;
    logic             Regfile_weE, memToRegE, memToRegM, branchD, jrD, pcSrcD;
    logic             excM, mdu_startE, mdu_ready, cnt_clr;
    logic             stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy;
    logic [CW-1:0]    stall_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsD           (rsD),
        .rtD           (rtD),
        .rtE           (rtE),
        .writeRegAddrE (writeRegAddrE),
        .writeRegAddrM (writeRegAddrM),
        .Regfile_weE   (Regfile_weE),
        .memToRegE     (memToRegE),
        .memToRegM     (memToRegM),
        .branchD       (branchD),
        .jrD           (jrD),
        .pcSrcD        (pcSrcD),
        .excM          (excM),
        .mdu_startE    (mdu_startE),
        .mdu_ready     (mdu_ready),
        .cnt_clr       (cnt_clr),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallE        (stallE),
        .flushD        (flushD),
        .flushE        (flushE),
        .flushM        (flushM),
        .mdu_busy      (mdu_busy),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rsD, rtD, rtE, wE, wM;
        logic       weE, m2rE, m2rM, branchD, jrD, pcSrcD, excM, start, ready, clr;
    } stim_t;

    // flags = {stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy}
    typedef struct {
        logic [6:0]    flags;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: an MDU op is "in flight" until ready/abort, then gets one release cycle.
    bit          m_inflight = 0;
    bit          m_release  = 0;
    int unsigned m_cnt      = 0;

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic bit hits(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        return (dst != 0) && ((dst == a) || (dst == b));
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   lw, br, hold, sf, sd, se, fd, fe, fm;
        @(posedge clk);
        #1;
        rst_n = s.rst_n;   rsD = s.rsD;   rtD = s.rtD;   rtE = s.rtE;
        writeRegAddrE = s.wE;  writeRegAddrM = s.wM;  Regfile_weE = s.weE;
        memToRegE = s.m2rE;    memToRegM = s.m2rM;    branchD = s.branchD;
        jrD = s.jrD;  pcSrcD = s.pcSrcD;  excM = s.excM;
        mdu_startE = s.start;  mdu_ready = s.ready;   cnt_clr = s.clr;
        if (!s.rst_n) begin
            m_inflight = 0;
            m_release  = 0;
            m_cnt      = 0;
            e.flags    = '0;
            e.cnt      = '0;
            sbq.push_back(e);
            return;
        end
        lw = s.m2rE && hits(s.rtE, s.rsD, s.rtD);
        br = (s.branchD || s.jrD) &&
             ((s.weE && hits(s.wE, s.rsD, s.rtD)) || (s.m2rM && hits(s.wM, s.rsD, s.rtD)));
`ifdef HAZARD_MDU_EN
        hold = m_inflight || (!m_release && s.start && !s.excM);
`else
        hold = 0;
`endif
        {sf, sd, se, fd, fe, fm} = '0;
        if (s.excM)          {fd, fe, fm} = 3'b111;
        else if (hold)       {sf, sd, se, fm} = 4'b1111;
        else if (lw || br)   {sf, sd, fe} = 3'b111;
        else                 fd = s.pcSrcD;
        e.flags = {sf, sd, se, fd, fe, fm, hold};
        e.cnt   = m_cnt[CW-1:0];
        sbq.push_back(e);

        if (s.clr)                        m_cnt = 0;
        else if (sf && m_cnt < CNT_MAX)   m_cnt = m_cnt + 1;

        if (m_inflight) begin
            if (s.excM)       m_inflight = 0;
            else if (s.ready) begin m_inflight = 0; m_release = 1; end
        end else if (m_release) begin
            m_release = 0;
        end else if (s.start && !s.excM) begin
            m_inflight = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t       e;
                logic [6:0] got;
                e   = sbq.pop_front();
                got = {stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy};
                checks++;
                if (got !== e.flags) begin
                    errors++;
                    $display("FAIL ctrl_flags t=%0t got=%b exp=%b (sF sD sE fD fE fM busy)",
                             $time, got, e.flags);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        {rsD, rtD, rtE, writeRegAddrE, writeRegAddrM} = '0;
        {Regfile_weE, memToRegE, memToRegM, branchD, jrD, pcSrcD} = '0;
        {excM, mdu_startE, mdu_ready, cnt_clr} = '0;

        // Reset with hazards present: everything must read zero.
        s = idle_s(); s.rst_n = 0; s.m2rE = 1; s.rtE = 3; s.rsD = 3; s.excM = 1; s.pcSrcD = 1;
        step(s); step(s);
        step(idle_s());

        // Load-use
        s = idle_s(); s.m2rE = 1; s.rtE = 9; s.rsD = 9;
        step(s);
        step(idle_s());

        // Branch compare hazards, then taken branch
        s = idle_s(); s.branchD = 1; s.rsD = 8; s.weE = 1; s.wE = 8;
        step(s);
        s = idle_s(); s.branchD = 1; s.rsD = 8; s.m2rM = 1; s.wM = 8;
        step(s);
        s = idle_s(); s.branchD = 1; s.rsD = 8; s.pcSrcD = 1;
        step(s);

        // $zero never stalls
        s = idle_s(); s.m2rE = 1; s.rtE = 0; s.rsD = 0;
        step(s);

        // MDU: start at cycle 0, ready at cycle 3, start held through the release cycle
        for (int i = 0; i < 6; i++) begin
            s = idle_s(); s.start = (i < 5); s.ready = (i == 3);
            step(s);
        end

        // MDU abort at cycle 2, late ready ignored
        for (int i = 0; i < 5; i++) begin
            s = idle_s(); s.start = (i < 3); s.excM = (i == 2); s.ready = (i == 3);
            step(s);
        end

        // Counter saturation then clear while stalling
        s = idle_s(); s.m2rE = 1; s.rtE = 5; s.rtD = 5;
        for (int i = 0; i < int'(CNT_MAX) + 4; i++) step(s);
        s.clr = 1; step(s);
        s.clr = 0; step(s);
        step(idle_s());

        // Reset mid-BUSY
        s = idle_s(); s.start = 1;
        step(s); step(s);
        s.rst_n = 0; step(s);
        step(idle_s()); step(idle_s());

        // Random traffic over a small register window to provoke matches
        for (int i = 0; i < 4000; i++) begin
            s = idle_s();
            s.rst_n   = ($urandom_range(0, 499) != 0);
            s.rsD     = 5'($urandom_range(0, 3));
            s.rtD     = 5'($urandom_range(0, 3));
            s.rtE     = 5'($urandom_range(0, 3));
            s.wE      = 5'($urandom_range(0, 3));
            s.wM      = 5'($urandom_range(0, 3));
            s.weE     = 1'($urandom_range(0, 1));
            s.m2rE    = ($urandom_range(0, 3) == 0);
            s.m2rM    = ($urandom_range(0, 3) == 0);
            s.branchD = ($urandom_range(0, 3) == 0);
            s.jrD     = ($urandom_range(0, 7) == 0);
            s.pcSrcD  = 1'($urandom_range(0, 1));
            s.excM    = ($urandom_range(0, 11) == 0);
            s.start   = ($urandom_range(0, 3) == 0);
            s.ready   = ($urandom_range(0, 2) == 0);
            s.clr     = ($urandom_range(0, 399) == 0);
            step(s);
        end
        step(idle_s());

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush sequencer for the 5-stage pipeline. Sits beside the forwarding unit and covers every hazard forwarding cannot resolve: load-use and branch-compare RAW hazards, taken-branch flushes, exception flushes, and the multi-cycle multiply/divide (MDU) hold. It drives the stall and flush controls of the F/D/E/M pipeline registers and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- rsD, rtD  in  `REG_SIZE  source registers in Decode
- rtE  in  `REG_SIZE  rt in Execute
- writeRegAddrE, writeRegAddrM  in  `REG_SIZE  destinations in E and M
- Regfile_weE  in  1  E instruction writes the register file
- memToRegE, memToRegM  in  1  E or M instruction is a load
- branchD, jrD  in  1  D is a branch or jr, compared in D
- pcSrcD  in  1  branch or jump taken in D
- excM  in  1  exception or eret in M
- mdu_startE  in  1  E holds a mult/div
- mdu_ready  in  1  MDU result valid
- cnt_clr  in  1  synchronous clear of stall_cnt
- stallF, stallD, stallE  out  1  hold PC, IF/ID, ID/EX
- flushD, flushE, flushM  out  1  bubble into IF/ID, ID/EX, EX/MEM
- mdu_busy  out  1  MDU sequence active
- stall_cnt  out  CNT_W  stallF-cycle count

## Operation
- lwstall = memToRegE & rtE≠0 & (rtE==rsD | rtE==rtD).
- brstall = (branchD|jrD) & [ (Regfile_weE & writeRegAddrE≠0 & writeRegAddrE∈{rsD,rtD}) | (memToRegM & writeRegAddrM≠0 & writeRegAddrM∈{rsD,rtD}) ].
- MDU FSM, 2-bit state:
  - IDLE: on mdu_startE & !excM → BUSY.
  - BUSY: on excM → IDLE; on mdu_ready → DONE.
  - DONE: one release cycle → IDLE. mdu_startE is ignored in DONE, so the same instruction is not restarted.
- mdu_hold = (IDLE & mdu_startE & !excM) | BUSY. mdu_busy = mdu_hold.
- Output priority, highest first:
  1. excM: flushD = flushE = flushM = 1, all stalls 0.
  2. mdu_hold: stallF = stallD = stallE = 1, flushM = 1. lwstall and brstall are masked.
  3. lwstall | brstall: stallF = stallD = 1, flushE = 1.
  4. Otherwise: flushD = pcSrcD.
- flushD is never asserted together with stallD.
- stall_cnt:
  - Increments on each clock edge where stallF = 1.
  - Saturates at all-ones.
  - cnt_clr has priority over increment; the value is 0 on the next edge.

## Timing
- Stall and flush outputs are combinational from inputs and state, valid in the same cycle; no added latency.
- MDU: mdu_startE in cycle N asserts the stalls in N. mdu_ready is sampled only in BUSY. Ready seen in cycle N+k (k≥1) → DONE in N+k+1, stalls low, E advances. Minimum hold is 2 cycles.
- mdu_ready while in IDLE or DONE is ignored.
- excM in BUSY aborts the sequence: flushes in that cycle, IDLE next.
- While rst_n = 0:
  - state = IDLE, stall_cnt = 0.
  - All outputs are forced to 0.
  - Release is synchronised by the standard reset synchroniser outside this block.

## Configuration
- HAZARD_MDU_EN defined: MDU FSM present, behaviour as above.
- HAZARD_MDU_EN undefined:
  - FSM removed; ports kept.
  - mdu_startE and mdu_ready ignored, mdu_hold = 0, mdu_busy tied 0.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the MDU state enum (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - the stall-counter width default.
- `REG_SIZE stays in the global defines header.
- One sub-module, mdu_seq: the FSM plus mdu_hold generation. The top level holds the hazard equations, output priority and counter.

## Test plan
- Load-use: lw $t1 in E (memToRegE=1, rtE=9), rsD=9 → stallF = stallD = flushE = 1 for one cycle; stall_cnt 0→1.
- Branch hazard: branchD=1, rsD=8, Regfile_weE=1, writeRegAddrE=8 → stall 1 cycle. Next cycle memToRegM=1, writeRegAddrM=8 → stall 1 more; then pcSrcD=1 → flushD=1, no stall.
- MDU: mdu_startE=1 at cycle 0, mdu_ready at cycle 3 → stalls high for cycles 0–3, DONE in cycle 4 with stalls low, IDLE in cycle 5.
- MDU abort: excM=1 at cycle 2 of BUSY → flushD/E/M = 1, stalls 0 that cycle; state IDLE next cycle; mdu_ready arriving afterwards is ignored.
- $zero: memToRegE=1, rtE=0, rsD=0 → no stall.
- Counter and reset: preload stall_cnt to 0xFFFE, hold stallF for 3 cycles → 0xFFFF saturated; cnt_clr → 0. Assert rst_n=0 mid-BUSY → outputs 0 immediately, state IDLE.
